// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler: FSM state encoding and
// default number of requesters.
package uart_pkg;

  localparam int unsigned DEFAULT_NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_START     = 2'b01,
    ST_WAIT_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or above rr_ptr,
// wrapping back to 0.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  int unsigned          idx;
  logic [NUM_REQ-1:0]   shifted;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    shifted   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx     = (32'(rr_ptr) + k) % NUM_REQ;
      shifted = eligible >> idx;
      if (!any_valid && shifted[0]) begin
        winner    = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ byte requesters with round-robin
// arbitration; all outputs registered.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [NUM_REQ-1:0]   i_req_mask,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic [ID_W-1:0]      o_grant_id,
  output logic [NUM_REQ-1:0]   o_byte_sent,
  output logic                 o_busy
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [NUM_REQ-1:0]   sent_q, sent_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic [7:0]           data_q, data_d;
  logic [NUM_REQ-1:0]   eligible;
  logic [ID_W-1:0]      winner;
  logic                 any_valid;

  assign eligible = i_req_valid & i_req_mask;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    start_d  = start_q;
    ready_d  = '0;
    sent_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && any_valid) begin
          state_d = ST_START;
          start_d = 1'b1;
          grant_d = winner;
          data_d  = 8'(i_req_data >> (8 * 32'(winner)));
          ready_d = NUM_REQ'(1) << winner;
        end
      end
      ST_START: begin
        if (i_tx_active) begin
          start_d = 1'b0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          sent_d  = NUM_REQ'(1) << grant_q;
          state_d = ST_IDLE;
          // Pointer moves past the requester just served, wrapping at NUM_REQ.
          if (32'(grant_q) + 1 >= NUM_REQ) rr_ptr_d = '0;
          else                             rr_ptr_d = grant_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      ready_q  <= '0;
      sent_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      start_q  <= start_d;
      ready_q  <= ready_d;
      sent_q   <= sent_d;
      busy_q   <= busy_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_tx_start  = start_q;
  assign o_tx_data   = data_q;
  assign o_grant_id  = grant_q;
  assign o_byte_sent = sent_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed vector table, hand-written
// multi-byte sequences, and randomized traffic against a transaction model.
module tb_uart_tx_sched;

  logic        clk;
  logic        rst, en, act, done;
  logic [3:0]  mask, valid;
  logic [31:0] data;
  logic [3:0]  o_req_ready, o_byte_sent;
  logic        o_tx_start, o_busy;
  logic [7:0]  o_tx_data;
  logic [1:0]  o_grant_id;
  logic [7:0]  bytes [4];

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_sched #(.NUM_REQ(4), .ID_W(2)) dut (
    .i_Clock     (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_req_mask  (mask),
    .i_req_valid (valid),
    .i_req_data  (data),
    .o_req_ready (o_req_ready),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .i_tx_active (act),
    .i_tx_done   (done),
    .o_grant_id  (o_grant_id),
    .o_byte_sent (o_byte_sent),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] r, input logic s, input logic [7:0] d,
                         input logic [1:0] g, input logic [3:0] sn, input logic b);
    chk({tag, ".ready"}, 32'(o_req_ready), 32'(r));
    chk({tag, ".start"}, 32'(o_tx_start),  32'(s));
    chk({tag, ".data"},  32'(o_tx_data),   32'(d));
    chk({tag, ".grant"}, 32'(o_grant_id),  32'(g));
    chk({tag, ".sent"},  32'(o_byte_sent), 32'(sn));
    chk({tag, ".busy"},  32'(o_busy),      32'(b));
  endtask

  typedef struct {
    logic       rst, en;
    logic [3:0] mask, valid;
    logic       act, done;
    logic [3:0] e_ready;
    logic       e_start;
    logic [7:0] e_data;
    logic [1:0] e_grant;
    logic [3:0] e_sent;
    logic       e_busy;
  } vec_t;

  vec_t tbl [19];

  // One full byte with the transmitter raising active 3 cycles after start.
  task automatic xfer(input int id, input string tag);
    int          w;
    logic [3:0]  onehot;
    logic [7:0]  b;
    onehot = 4'(1 << id);
    b      = bytes[id[1:0]];
    w      = 0;
    act    = 1'b0;
    done   = 1'b0;
    while (o_req_ready == 4'h0 && w < 20) begin
      step();
      w++;
    end
    chk({tag, ".grant_in_time"}, 32'(w < 20), 32'd1);
    chk({tag, ".ready"}, 32'(o_req_ready), 32'(onehot));
    chk({tag, ".grant"}, 32'(o_grant_id), 32'(id));
    chk({tag, ".data"},  32'(o_tx_data), 32'(b));
    chk({tag, ".start1"}, 32'(o_tx_start), 32'd1);
    step();
    chk({tag, ".start2"}, 32'(o_tx_start), 32'd1);
    chk({tag, ".ready_once"}, 32'(o_req_ready), 32'd0);
    step();
    chk({tag, ".start3"}, 32'(o_tx_start), 32'd1);
    act = 1'b1;
    step();
    chk({tag, ".start_low"}, 32'(o_tx_start), 32'd0);
    repeat (3) begin
      step();
      chk({tag, ".data_hold"}, 32'(o_tx_data), 32'(b));
      chk({tag, ".no_sent"}, 32'(o_byte_sent), 32'd0);
    end
    act  = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    chk({tag, ".sent"}, 32'(o_byte_sent), 32'(onehot));
    chk({tag, ".idle"}, 32'(o_busy), 32'd0);
  endtask

  // Transaction-level reference state for the randomized run.
  int         m_owner, m_ptr, phase, cnt;
  bit         m_hs;
  logic [3:0] e_ready, e_sent, elig;
  logic       e_start, e_busy;
  logic [7:0] e_data;
  logic [1:0] e_grant;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_hs = 0;
    e_ready = '0; e_sent = '0; e_start = 0; e_busy = 0; e_data = '0; e_grant = '0;
  endtask

  task automatic model_predict();
    if (rst) begin
      model_reset();
      return;
    end
    e_ready = '0;
    e_sent  = '0;
    elig    = valid & mask;
    if (m_owner < 0) begin
      if (en && elig != 4'h0) begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (m_ptr + k) % 4;
          if (m_owner < 0 && elig[c[1:0]]) m_owner = c;
        end
        m_hs    = 0;
        e_data  = bytes[m_owner[1:0]];
        e_grant = m_owner[1:0];
        e_ready = 4'(1 << m_owner);
      end
    end else if (!m_hs) begin
      if (act) m_hs = 1;
    end else if (done) begin
      e_sent  = 4'(1 << m_owner);
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end
    e_start = (m_owner >= 0) && !m_hs;
    e_busy  = (m_owner >= 0);
  endtask

  initial begin
    tbl[0]  = '{1'b1,1'b1,4'hF,4'h0,1'b0,1'b0, 4'h0,1'b0,8'h00,2'd0,4'h0,1'b0};
    tbl[1]  = '{1'b0,1'b1,4'hF,4'h1,1'b0,1'b0, 4'h1,1'b1,8'hA5,2'd0,4'h0,1'b1};
    tbl[2]  = '{1'b0,1'b1,4'hF,4'h0,1'b0,1'b0, 4'h0,1'b1,8'hA5,2'd0,4'h0,1'b1};
    tbl[3]  = '{1'b0,1'b1,4'hF,4'h0,1'b1,1'b0, 4'h0,1'b0,8'hA5,2'd0,4'h0,1'b1};
    tbl[4]  = '{1'b0,1'b1,4'hF,4'h0,1'b1,1'b0, 4'h0,1'b0,8'hA5,2'd0,4'h0,1'b1};
    tbl[5]  = '{1'b0,1'b1,4'hF,4'h0,1'b0,1'b1, 4'h0,1'b0,8'hA5,2'd0,4'h1,1'b0};
    tbl[6]  = '{1'b0,1'b1,4'hF,4'hF,1'b0,1'b0, 4'h2,1'b1,8'h5A,2'd1,4'h0,1'b1};
    tbl[7]  = '{1'b0,1'b1,4'hF,4'hD,1'b0,1'b1, 4'h0,1'b1,8'h5A,2'd1,4'h0,1'b1};
    tbl[8]  = '{1'b0,1'b1,4'hF,4'hD,1'b1,1'b0, 4'h0,1'b0,8'h5A,2'd1,4'h0,1'b1};
    tbl[9]  = '{1'b0,1'b1,4'hF,4'hD,1'b0,1'b1, 4'h0,1'b0,8'h5A,2'd1,4'h2,1'b0};
    tbl[10] = '{1'b0,1'b1,4'hF,4'hD,1'b0,1'b0, 4'h4,1'b1,8'h3C,2'd2,4'h0,1'b1};
    tbl[11] = '{1'b0,1'b0,4'hF,4'h9,1'b1,1'b0, 4'h0,1'b0,8'h3C,2'd2,4'h0,1'b1};
    tbl[12] = '{1'b0,1'b0,4'hF,4'h9,1'b0,1'b1, 4'h0,1'b0,8'h3C,2'd2,4'h4,1'b0};
    tbl[13] = '{1'b0,1'b0,4'hF,4'h9,1'b0,1'b0, 4'h0,1'b0,8'h3C,2'd2,4'h0,1'b0};
    tbl[14] = '{1'b0,1'b0,4'hF,4'h9,1'b1,1'b1, 4'h0,1'b0,8'h3C,2'd2,4'h0,1'b0};
    tbl[15] = '{1'b0,1'b1,4'h7,4'h9,1'b0,1'b0, 4'h1,1'b1,8'hA5,2'd0,4'h0,1'b1};
    tbl[16] = '{1'b0,1'b1,4'hF,4'h8,1'b1,1'b0, 4'h0,1'b0,8'hA5,2'd0,4'h0,1'b1};
    tbl[17] = '{1'b1,1'b1,4'hF,4'h8,1'b0,1'b1, 4'h0,1'b0,8'h00,2'd0,4'h0,1'b0};
    tbl[18] = '{1'b0,1'b1,4'hF,4'hB,1'b0,1'b0, 4'h1,1'b1,8'hA5,2'd0,4'h0,1'b1};

    bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'h3C; bytes[3] = 8'h7E;
    data = {bytes[3], bytes[2], bytes[1], bytes[0]};
    rst = 1'b1; en = 1'b0; mask = 4'h0; valid = 4'h0; act = 1'b0; done = 1'b0;
    step();

    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; mask = tbl[i].mask; valid = tbl[i].valid;
      act = tbl[i].act; done = tbl[i].done;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_start, tbl[i].e_data,
              tbl[i].e_grant, tbl[i].e_sent, tbl[i].e_busy);
    end

    rst = 1'b1; act = 1'b0; done = 1'b0; step(); rst = 1'b0;
    en = 1'b1; mask = 4'hF; valid = 4'hF;
    xfer(0, "rr0"); xfer(1, "rr1"); xfer(2, "rr2"); xfer(3, "rr3"); xfer(0, "rr4");

    rst = 1'b1; step(); rst = 1'b0;
    mask = 4'b1010; valid = 4'hF;
    xfer(1, "mk0"); xfer(3, "mk1"); xfer(1, "mk2");

    rst = 1'b1; act = 1'b0; done = 1'b0; valid = 4'h0; mask = 4'hF; en = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    phase = 0; cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 4; n++) begin
        if (o_req_ready[n[1:0]]) valid[n[1:0]] = 1'b0;
        else if (!valid[n[1:0]] && $urandom_range(0, 3) == 0) begin
          valid[n[1:0]] = 1'b1;
          bytes[n[1:0]] = 8'($urandom);
        end else if (!valid[n[1:0]]) bytes[n[1:0]] = 8'($urandom);
      end
      data = {bytes[3], bytes[2], bytes[1], bytes[0]};
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 299) == 0);
      if (rst) begin
        phase = 0; act = 1'b0; done = 1'b0;
      end else if (phase == 2) begin
        done = 1'b0;
        if (cnt == 0) begin act = 1'b0; done = 1'b1; phase = 0; end
        else begin act = 1'b1; cnt--; end
      end else begin
        if (phase == 0) begin
          act  = ($urandom_range(0, 9) == 0);
          done = ($urandom_range(0, 9) == 0);
          if (o_tx_start) begin phase = 1; cnt = $urandom_range(0, 3); end
        end
        if (phase == 1) begin
          done = ($urandom_range(0, 5) == 0);
          if (cnt == 0) begin act = 1'b1; phase = 2; cnt = $urandom_range(1, 5); end
          else begin act = 1'b0; cnt--; end
        end
      end
      model_predict();
      step();
      chk_all("rand", e_ready, e_start, e_data, e_grant, e_sent, e_busy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one UART transmitter (1..8).
REQ-002 Parameter ID_W, default 2, width of requester index (clog2(NUM_REQ), min 1).
REQ-003 i_Clock  input  1  single clock for all logic.
REQ-004 i_reset  input  1  reset, synchronous, active-high.
REQ-005 i_enable  input  1  global enable; low blocks new grants, in-flight byte completes.
REQ-006 i_req_mask  input  NUM_REQ  per-requester enable; bit 0 excludes that requester from arbitration.
REQ-007 i_req_valid  input  NUM_REQ  requester n has a byte pending; held until its o_req_ready pulse.
REQ-008 i_req_data  input  8*NUM_REQ  byte of requester n at bits [8n+7:8n].
REQ-009 o_req_ready  output  NUM_REQ  one-hot, one-cycle pulse: byte of requester n accepted.
REQ-010 o_tx_start  output  1  start request to transmitter.
REQ-011 o_tx_data  output  8  byte to transmitter, stable from o_tx_start rise to i_tx_done.
REQ-012 i_tx_active  input  1  transmitter busy flag.
REQ-013 i_tx_done  input  1  transmitter one-cycle completion pulse.
REQ-014 o_grant_id  output  ID_W  index of requester owning the current transfer.
REQ-015 o_byte_sent  output  NUM_REQ  one-hot, one-cycle pulse: requester n's byte finished on the line.
REQ-016 o_busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, START, WAIT_DONE; all outputs registered.
REQ-018 IDLE: eligible = i_req_valid & i_req_mask; if i_enable=1 and eligible!=0, winner = first eligible index searching upward from rr_ptr with wrap to 0.
REQ-019 On that edge: latch i_req_data[winner] into o_tx_data, o_grant_id<=winner, o_req_ready[winner]<=1 for exactly one cycle, o_tx_start<=1, state->START.
REQ-020 Latency: eligible request in IDLE cycle N -> o_req_ready and o_tx_start high in cycle N+1.
REQ-021 START: hold o_tx_start=1 until i_tx_active=1 sampled; then o_tx_start<=0, state->WAIT_DONE.
REQ-022 WAIT_DONE: on i_tx_done=1 -> o_byte_sent[o_grant_id]<=1 for one cycle, rr_ptr<=(o_grant_id+1) mod NUM_REQ, state->IDLE.
REQ-023 Minimum gap: i_tx_done in cycle D -> next o_tx_start no earlier than cycle D+2.
REQ-024 i_tx_done in IDLE or START ignored; i_tx_active in IDLE/WAIT_DONE ignored.
REQ-025 Changes to i_req_mask, i_req_valid, i_req_data, i_enable after acceptance do not affect the in-flight byte.
REQ-026 Simultaneous i_tx_done and new requests: completion processed first; arbitration in following IDLE cycle using updated rr_ptr.
REQ-027 NUM_REQ=1: rr_ptr stays 0; behaviour otherwise identical.
REQ-028 Invalid state encoding -> IDLE next cycle.

Reset
REQ-029 i_reset=1 at a clock edge: state IDLE, rr_ptr=0, o_req_ready=0, o_tx_start=0, o_tx_data=8'h00, o_grant_id=0, o_byte_sent=0, o_busy=0.
REQ-030 Reset mid-transfer aborts it with no o_byte_sent pulse; requester's byte counts as consumed if o_req_ready already pulsed.
REQ-031 Reset dominates i_enable and all inputs.

Structure
REQ-032 Shared package uart_pkg holds FSM state typedef/encodings and default NUM_REQ.
REQ-033 Round-robin selection in sub-module rr_arbiter (inputs eligible, rr_ptr; outputs winner index, any_valid), purely combinational.
REQ-034 Scheduler FSM, data latch and pointer register live in uart_tx_sched.

Verification
REQ-035 Reset, req_valid=4'b0001, data0=8'hA5, tx model done 10 cycles after active -> ready[0] pulse, o_tx_data=8'hA5, o_byte_sent=4'b0001, o_busy back to 0.
REQ-036 All four valid continuously, mask=4'hF -> grant order 0,1,2,3,0; each ready pulse exactly once per byte.
REQ-037 mask=4'b1010, valid=4'hF -> grants alternate 1,3,1; requesters 0,2 never see ready.
REQ-038 i_enable dropped during WAIT_DONE -> byte completes, o_byte_sent pulses, no new o_tx_start until i_enable=1.
REQ-039 Transmitter raises i_tx_active 3 cycles after start -> o_tx_start stays high 3 cycles, then low; data unchanged through i_tx_done.
REQ-040 i_reset pulsed in WAIT_DONE -> all outputs reset values next cycle, no o_byte_sent; next grant starts from requester 0.
